// File: rtl/ucode_loader_if.sv
// Load-stream handshake between the host/debug port and the microcode loader.
// The host drives words with valid; the loader answers with ready.
interface ucode_loader_if #(
    parameter int P_WORDWIDTH = 11
);
    logic                   s_valid;
    logic [P_WORDWIDTH-1:0] s_data;
    logic                   s_ready;

    modport master (output s_valid, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/ucode_loader.sv
// Microcode loader and run controller: streams a program into the sequencer's
// instruction memory, then gates its enable for run/pause/step/breakpoint.
module ucode_loader #(
    parameter int P_LOG_MEMSIZE = 4,
    parameter int P_WORDWIDTH   = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    ucode_loader_if.slave            strm,
    input  logic                     load_start,
    input  logic [P_LOG_MEMSIZE:0]   load_len,
    input  logic                     run,
    input  logic                     step,
    input  logic                     halt_en,
    input  logic [P_LOG_MEMSIZE-1:0] halt_addr,
    input  logic [P_LOG_MEMSIZE-1:0] seq_addr,
    output logic                     imem_we,
    output logic [P_LOG_MEMSIZE-1:0] imem_waddr,
    output logic [P_WORDWIDTH-1:0]   imem_wdata,
    output logic                     seq_rst,
    output logic                     seq_en,
    output logic                     loaded,
    output logic                     busy,
    output logic                     halted
);
    localparam int LP_MEMSIZE = 1 << P_LOG_MEMSIZE;
    localparam logic [P_LOG_MEMSIZE:0] MEMSIZE_W = (P_LOG_MEMSIZE+1)'(LP_MEMSIZE);

    typedef enum logic [2:0] {IDLE, LOAD, PAUSE, RUN, HALT} state_t;

    state_t                 state, state_nx;
    logic [P_LOG_MEMSIZE:0] cnt, len, len_clamped;
    logic                   start_ok, hs, last, hit;

    assign len_clamped = (load_len > MEMSIZE_W) ? MEMSIZE_W : load_len;
    assign start_ok    = load_start && (load_len != '0) &&
                         (state == IDLE || state == PAUSE || state == HALT);
    assign hs          = (state == LOAD) && strm.s_valid;
    assign last        = (cnt == len - 1'b1);
    // Combinational so the sequencer is frozen in the very cycle it reaches the breakpoint.
    assign hit         = halt_en && (seq_addr == halt_addr);

    assign strm.s_ready = (state == LOAD);
    assign imem_we      = hs;
    assign imem_waddr   = cnt[P_LOG_MEMSIZE-1:0];
    assign imem_wdata   = strm.s_data;
    assign busy         = (state == LOAD) || (state == RUN);
    assign halted       = (state == HALT);

    always_comb begin
        state_nx = state;
        seq_en   = 1'b0;
        case (state)
            IDLE:  if (start_ok) state_nx = LOAD;
            LOAD:  if (hs && last) state_nx = PAUSE;
            PAUSE: begin
                if (start_ok)             state_nx = LOAD;
                else if (run && loaded)   state_nx = RUN;
                else if (step && loaded)  seq_en   = 1'b1;
            end
            RUN: begin
                seq_en = run && !hit;
                if (hit)       state_nx = HALT;
                else if (!run) state_nx = PAUSE;
            end
            HALT: begin
                if (start_ok) state_nx = LOAD;
                else if (step) begin
                    seq_en   = 1'b1;
                    state_nx = PAUSE;
                end else if (!run) state_nx = PAUSE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            len     <= '0;
            loaded  <= 1'b0;
            seq_rst <= 1'b1;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                len    <= len_clamped;
                cnt    <= '0;
                loaded <= 1'b0;
            end else if (hs) begin
                cnt <= cnt + 1'b1;
                if (last) loaded <= 1'b1;
            end
            // Registered from the next state so the sequencer reset is glitch-free.
            seq_rst <= (state_nx == IDLE) || (state_nx == LOAD);
        end
    end
endmodule

// File: tb/tb_ucode_loader.sv
// Scoreboard bench for ucode_loader: expected writes queued as beats are driven,
// popped when the write strobe fires; a tiny sequencer model drives seq_addr.
module tb_ucode_loader;
    localparam int LG = 4;
    localparam int W  = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic [LG:0]   load_len;
    logic          run, step, halt_en;
    logic [LG-1:0] halt_addr, seq_addr;
    logic          imem_we;
    logic [LG-1:0] imem_waddr;
    logic [W-1:0]  imem_wdata;
    logic          seq_rst, seq_en, loaded, busy, halted;

    ucode_loader_if #(.P_WORDWIDTH(W)) lif ();

    ucode_loader #(.P_LOG_MEMSIZE(LG), .P_WORDWIDTH(W)) dut (
        .clk(clk), .rst(rst), .strm(lif),
        .load_start(load_start), .load_len(load_len),
        .run(run), .step(step), .halt_en(halt_en), .halt_addr(halt_addr),
        .seq_addr(seq_addr),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .seq_rst(seq_rst), .seq_en(seq_en),
        .loaded(loaded), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int en_cnt = 0;

    typedef struct packed {
        logic [LG-1:0] a;
        logic [W-1:0]  d;
    } wr_t;
    wr_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Sequencer model: held at 0 in reset, advances one address per enable.
    always @(posedge clk or posedge rst) begin
        if (rst)          seq_addr <= '0;
        else if (seq_rst) seq_addr <= '0;
        else if (seq_en)  seq_addr <= seq_addr + 1'b1;
    end

    always @(negedge clk) begin
        wr_t e;
        if (seq_en) en_cnt++;
        if (imem_we) begin
            if (sb.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
                e = sb.pop_front();
                chk("wr_addr", 32'(imem_waddr), 32'(e.a));
                chk("wr_data", 32'(imem_wdata), 32'(e.d));
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int nbeats, input bit gaps, input int base, input bit complete);
        for (int i = 0; i < nbeats; i++) begin
            if (gaps && (i % 2 == 1)) begin
                lif.s_valid = 1'b0;
                @(negedge clk);
                chk("gap_we", 32'(imem_we), 0);
                chk("gap_ready", 32'(lif.s_ready), 1);
                nxt();
            end
            lif.s_valid = 1'b1;
            lif.s_data  = W'(base * (i + 1));
            sb.push_back({LG'(i), lif.s_data});
            @(negedge clk);
            chk("ld_ready", 32'(lif.s_ready), 1);
            chk("ld_seq_rst", 32'(seq_rst), 1);
            chk("ld_loaded", 32'(loaded), 0);
            nxt();
        end
        lif.s_valid = 1'b0;
        if (complete) begin
            @(negedge clk);
            chk("done_loaded", 32'(loaded), 1);
            chk("done_seq_rst", 32'(seq_rst), 0);
            chk("done_busy", 32'(busy), 0);
            chk("done_ready", 32'(lif.s_ready), 0);
            nxt();
        end
    endtask

    task automatic do_load(input int len, input int nbeats, input bit gaps, input int base,
                           input bit complete);
        load_start = 1'b1;
        load_len   = (LG+1)'(len);
        @(negedge clk);
        chk("start_ready", 32'(lif.s_ready), 0);
        nxt();
        load_start = 1'b0;
        feed(nbeats, gaps, base, complete);
    endtask

    initial begin
        int  e0;
        bit  found;
        rst = 1'b1; load_start = 0; load_len = '0; run = 0; step = 0;
        halt_en = 0; halt_addr = '0;
        lif.s_valid = 1'b0; lif.s_data = W'(11'h055);
        #1;
        chk("rst_ready", 32'(lif.s_ready), 0);
        chk("rst_we", 32'(imem_we), 0);
        chk("rst_en", 32'(seq_en), 0);
        chk("rst_loaded", 32'(loaded), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_waddr", 32'(imem_waddr), 0);
        chk("rst_wdata", 32'(imem_wdata), 32'h055);
        chk("rst_seq_rst", 32'(seq_rst), 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 3-word load with valid gaps: 0x101, 0x202, 0x303
        do_load(3, 3, 1'b1, 'h101, 1'b1);

        // zero length is ignored
        load_start = 1'b1; load_len = '0;
        @(negedge clk); nxt();
        load_start = 1'b0;
        @(negedge clk);
        chk("len0_busy", 32'(busy), 0);
        chk("len0_ready", 32'(lif.s_ready), 0);
        chk("len0_loaded", 32'(loaded), 1);
        nxt();

        // oversize length clamps to 16 words; a further beat must not write
        do_load(20, 16, 1'b0, 'h41, 1'b1);
        lif.s_valid = 1'b1; lif.s_data = W'(11'h7ff);
        @(negedge clk);
        chk("over_we", 32'(imem_we), 0);
        nxt();
        lif.s_valid = 1'b0;

        // run to breakpoint at address 5
        halt_en = 1'b1; halt_addr = LG'(5); run = 1'b1;
        e0 = en_cnt;
        @(negedge clk);
        chk("run_pause_en", 32'(seq_en), 0);
        nxt();
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (seq_addr == LG'(5)) begin
                found = 1'b1;
                chk("bp_en_low", 32'(seq_en), 0);
                chk("bp_busy", 32'(busy), 1);
            end
            nxt();
        end
        chk("bp_reached", 32'(found), 1);
        @(negedge clk);
        chk("bp_halted", 32'(halted), 1);
        chk("bp_addr", 32'(seq_addr), 5);
        chk("bp_run_cycles", 32'(en_cnt - e0), 5);
        nxt();
        @(negedge clk);
        chk("bp_hold", 32'(halted), 1);
        chk("bp_hold_addr", 32'(seq_addr), 5);
        nxt();

        // step out of the breakpoint
        run = 1'b0; step = 1'b1;
        @(negedge clk);
        chk("halt_step_en", 32'(seq_en), 1);
        nxt();
        step = 1'b0;
        @(negedge clk);
        chk("halt_step_halted", 32'(halted), 0);
        chk("halt_step_busy", 32'(busy), 0);
        chk("halt_step_addr", 32'(seq_addr), 6);
        nxt();

        // three single steps in PAUSE
        e0 = en_cnt;
        repeat (3) begin
            step = 1'b1;
            @(negedge clk);
            chk("step_en", 32'(seq_en), 1);
            nxt();
            step = 1'b0;
            @(negedge clk);
            chk("step_gap", 32'(seq_en), 0);
            nxt();
        end
        chk("step_count", 32'(en_cnt - e0), 3);
        chk("step_addr", 32'(seq_addr), 9);

        // load_start beats run and step
        run = 1'b1; step = 1'b1; load_start = 1'b1; load_len = (LG+1)'(2);
        @(negedge clk);
        chk("prio_en", 32'(seq_en), 0);
        nxt();
        run = 1'b0; step = 1'b0; load_start = 1'b0;
        @(negedge clk);
        chk("prio_busy", 32'(busy), 1);
        nxt();
        feed(2, 1'b0, 'h33, 1'b1);

        // load_start during RUN is ignored
        halt_en = 1'b0; run = 1'b1;
        nxt();
        load_start = 1'b1; load_len = (LG+1)'(3);
        @(negedge clk);
        chk("run_ld_en", 32'(seq_en), 1);
        nxt();
        load_start = 1'b0;
        @(negedge clk);
        chk("run_ld_busy", 32'(busy), 1);
        chk("run_ld_ready", 32'(lif.s_ready), 0);
        chk("run_ld_seq_rst", 32'(seq_rst), 0);
        nxt();
        run = 1'b0;
        nxt();
        @(negedge clk);
        chk("run_off_busy", 32'(busy), 0);
        nxt();

        // reset part way through a 4-word load
        do_load(4, 2, 1'b0, 'h11, 1'b0);
        rst = 1'b1;
        #1;
        chk("abort_loaded", 32'(loaded), 0);
        chk("abort_seq_rst", 32'(seq_rst), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ready", 32'(lif.s_ready), 0);
        nxt();
        rst = 1'b0;
        run = 1'b1; step = 1'b1;
        @(negedge clk);
        chk("idle_step_en", 32'(seq_en), 0);
        nxt();
        step = 1'b0;
        @(negedge clk);
        chk("idle_run_busy", 32'(busy), 0);
        chk("idle_run_en", 32'(seq_en), 0);
        nxt();
        run = 1'b0;
        do_load(4, 4, 1'b1, 'h2a, 1'b1);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
